button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 100000, meaning the clock cycles the synchronized input must be stable before a state change is accepted (minimum 2).
REQ-002 SHALL have parameter LONG_CYCLES, default 50000000, meaning the clock cycles after PRESS at which a long press is reported (minimum 1); used only when BUTTON_LONGPRESS_EN is defined.
REQ-003 SHALL have port CLK  input  1  system clock; all logic on posedge CLK.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port BUT  input  1  raw button pin; asynchronous to CLK, bouncing, active-low (0 = pressed).
REQ-006 SHALL have port PRESS  output  1  one-cycle pulse on each accepted press.
REQ-007 SHALL have port RELEASE  output  1  one-cycle pulse on each accepted release.
REQ-008 SHALL have port PRESSED  output  1  debounced level (1 = held).
REQ-009 SHALL have port LONG  output  1  one-cycle pulse when a held press reaches LONG_CYCLES.

Function
REQ-010 SHALL pass BUT through a two-flop synchronizer; later logic uses only the synchronized value (sync).
REQ-011 SHALL implement the states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, using one debounce counter of width $clog2(DEBOUNCE_CYCLES).
REQ-012 In IDLE, sync=0 SHALL go to PRESS_WAIT with counter=0; sync=1 SHALL stay in IDLE.
REQ-013 In PRESS_WAIT, sync=1 SHALL return to IDLE (bounce rejected, no pulse); sync=0 SHALL increment the counter; counter==DEBOUNCE_CYCLES-1 with sync=0 SHALL go to HELD and assert PRESS for exactly one cycle.
REQ-014 In HELD, sync=1 SHALL go to RELEASE_WAIT with counter=0.
REQ-015 In RELEASE_WAIT, sync=0 SHALL return to HELD (no pulse); counter==DEBOUNCE_CYCLES-1 with sync=1 SHALL go to IDLE and assert RELEASE for exactly one cycle.
REQ-016 Latency: with BUT low and stable, counting the first edge that samples BUT low as edge 0, PRESS SHALL be high in the cycle after edge DEBOUNCE_CYCLES+2; release latency SHALL be symmetric.
REQ-017 PRESSED SHALL be 1 exactly while the state is HELD or RELEASE_WAIT, registered, rising in the same cycle as PRESS and falling in the same cycle as RELEASE.
REQ-018 PRESS and RELEASE SHALL never be high in the same cycle; a bounce within the window SHALL restart counting from 0 on the next stable sample.
REQ-019 PRESS, RELEASE and LONG SHALL be registered outputs with no combinational path from BUT.

Reset
REQ-020 When RST_N=0, the block SHALL immediately enter IDLE, clear all counters, drive PRESS=RELEASE=PRESSED=LONG=0, and set both synchronizer flops to 1 (released).
REQ-021 When reset is asserted mid-press, the press SHALL be abandoned with no RELEASE pulse; if BUT is still low after RST_N rises, a fresh PRESS SHALL follow per REQ-016.

Configuration
REQ-022 With BUTTON_LONGPRESS_EN defined, a saturating long counter SHALL clear on PRESS and count in HELD and RELEASE_WAIT; on reaching LONG_CYCLES it SHALL pulse LONG for one cycle, at most once per press; it SHALL clear on entry to IDLE.
REQ-023 Without BUTTON_LONGPRESS_EN, LONG SHALL be tied to 0 and no long-press counter logic SHALL be present.

Structure
REQ-024 The shared package SHALL hold the state encoding constants (ST_IDLE, ST_PRESS_WAIT, ST_HELD, ST_RELEASE_WAIT, 2 bits) and the default parameter values.
REQ-025 The synchronizer SHALL be a separate sub-module, sync2 (parameter reset value, async active-low reset), so that other pin inputs can reuse it.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-026 Reset, then BUT=0 held from edge 0 -> PRESS high for one cycle after edge 6; PRESSED=1 from the same cycle; RELEASE=0 throughout.
REQ-027 From IDLE, BUT toggles 0/1/0/1 every 2 cycles for 20 cycles, then stays 1 -> PRESS, RELEASE and PRESSED stay 0.
REQ-028 While HELD, BUT=1 for 3 cycles then back to 0 -> no RELEASE and PRESSED stays 1; BUT=1 held -> RELEASE one cycle after edge 6 of the release, PRESSED=0.
REQ-029 Reset asserted 3 cycles after PRESS while BUT stays 0 -> all outputs 0 immediately; after deassertion, PRESS again after DEBOUNCE_CYCLES+2 edges; no RELEASE.
REQ-030 With BUTTON_LONGPRESS_EN, hold for 40 cycles after PRESS -> a single LONG pulse 20 cycles after PRESS; without the macro -> LONG constant 0.

Source files
------------

// File: rtl/button_debounce_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// default timing parameters.
package button_debounce_pkg;

    // Debouncer FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    // Default stability window and long-press time, in clock cycles.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 100000;
    localparam int unsigned DEF_LONG_CYCLES     = 50000000;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input pin. The reset value
// is a parameter so that pins with either idle level can share this block.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic d,
    output logic q
);

    logic meta;

    // Double-register the async input to resolve metastability.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer for an active-low, bouncing pin. Produces one-cycle
// PRESS/RELEASE pulses and a debounced PRESSED level.
// Optional long-press detection is enabled by defining BUTTON_LONGPRESS_EN;
// without it LONG is tied low and no long-press counter exists.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BUT,
    output logic PRESS,
    output logic RELEASE,
    output logic PRESSED,
    output logic LONG
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync;
    state_t        state;
    logic [CW-1:0] dbc_cnt;

    // Reset to 1 so a held button after reset still goes through a full debounce.
    sync2 #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .CLK  (CLK),
        .RST_N(RST_N),
        .d    (BUT),
        .q    (sync)
    );

    // Debounce FSM with registered PRESS/RELEASE pulses and PRESSED level.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            dbc_cnt <= '0;
            PRESS   <= 1'b0;
            RELEASE <= 1'b0;
            PRESSED <= 1'b0;
        end else begin
            PRESS   <= 1'b0;
            RELEASE <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (!sync) begin
                        state   <= ST_PRESS_WAIT;
                        dbc_cnt <= '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (sync) begin
                        // Bounce: drop back without reporting anything.
                        state <= ST_IDLE;
                    end else if (dbc_cnt == CNT_LAST) begin
                        state   <= ST_HELD;
                        dbc_cnt <= '0;
                        PRESS   <= 1'b1;
                        PRESSED <= 1'b1;
                    end else begin
                        dbc_cnt <= dbc_cnt + CW'(1);
                    end
                end
                ST_HELD: begin
                    if (sync) begin
                        state   <= ST_RELEASE_WAIT;
                        dbc_cnt <= '0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (!sync) begin
                        state <= ST_HELD;
                    end else if (dbc_cnt == CNT_LAST) begin
                        state   <= ST_IDLE;
                        dbc_cnt <= '0;
                        RELEASE <= 1'b1;
                        PRESSED <= 1'b0;
                    end else begin
                        dbc_cnt <= dbc_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BUTTON_LONGPRESS_EN
    localparam int unsigned   LW       = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] LONG_SAT = LW'(LONG_CYCLES);

    logic [LW-1:0] long_cnt;
    logic          press_accept;
    logic          release_accept;

    assign press_accept   = (state == ST_PRESS_WAIT) && !sync && (dbc_cnt == CNT_LAST);
    assign release_accept = (state == ST_RELEASE_WAIT) && sync && (dbc_cnt == CNT_LAST);

    // Saturating hold-time counter; LONG fires once when it first reaches LONG_CYCLES.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            long_cnt <= '0;
            LONG     <= 1'b0;
        end else begin
            LONG <= 1'b0;
            if (press_accept || release_accept) begin
                long_cnt <= '0;
            end else if ((state == ST_HELD || state == ST_RELEASE_WAIT) &&
                         (long_cnt != LONG_SAT)) begin
                long_cnt <= long_cnt + LW'(1);
                if (long_cnt == LONG_SAT - LW'(1)) begin
                    LONG <= 1'b1;
                end
            end
        end
    end
`else
    // Long-press feature compiled out.
    assign LONG = 1'b0;

    logic unused_long_cfg;
    assign unused_long_cfg = ^LONG_CYCLES;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce (DEBOUNCE_CYCLES=4, LONG_CYCLES=20).
// Expected pulses are queued with their edge index when stimulus is driven;
// pulses seen on the outputs are queued by the clock helper and matched per test.
module tb_button_debounce;

    localparam int unsigned DC = 4;
    localparam int unsigned LC = 20;

    localparam int EV_PRESS   = 0;
    localparam int EV_RELEASE = 1;
    localparam int EV_LONG    = 2;

    typedef struct {
        int kind;
        int edge_no;
    } ev_t;

    logic CLK;
    logic RST_N;
    logic BUT;
    logic PRESS;
    logic RELEASE;
    logic PRESSED;
    logic LONG;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  edge_idx = 0;
    int  n_vec    = 0;
    int  n_err    = 0;

    button_debounce #(
        .DEBOUNCE_CYCLES(DC),
        .LONG_CYCLES    (LC)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .BUT    (BUT),
        .PRESS  (PRESS),
        .RELEASE(RELEASE),
        .PRESSED(PRESSED),
        .LONG   (LONG)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One clock: count the posedge, then record any output pulses at the negedge.
    task automatic tick();
        @(posedge CLK);
        edge_idx++;
        @(negedge CLK);
        if (PRESS === 1'b1)   obs_q.push_back('{EV_PRESS, edge_idx});
        if (RELEASE === 1'b1) obs_q.push_back('{EV_RELEASE, edge_idx});
        if (LONG === 1'b1)    obs_q.push_back('{EV_LONG, edge_idx});
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        BUT   = 1'b1;
        #1;
        n_vec++;
        if ({PRESS, RELEASE, PRESSED, LONG} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b, want 0000", {PRESS, RELEASE, PRESSED, LONG});
        end
        repeat (3) tick();
        RST_N = 1'b1;
        repeat (3) tick();
        n_vec++;
        if ({PRESS, RELEASE, PRESSED, LONG} !== 4'b0000) begin
            n_err++;
            $display("FAIL idle_outputs: got %b, want 0000", {PRESS, RELEASE, PRESSED, LONG});
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL reset_pulses: got %0d pulses, want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_press_long();
        int e0;
        ev_t ex;
        ev_t ob;
        BUT = 1'b0;
        e0  = edge_idx + 1;
        exp_q.push_back('{EV_PRESS, e0 + DC + 2});
`ifdef BUTTON_LONGPRESS_EN
        exp_q.push_back('{EV_LONG, e0 + DC + 2 + LC});
`endif
        for (int i = 0; i < DC + 2 + 40; i++) begin
            tick();
            n_vec++;
            if (PRESSED !== (edge_idx >= e0 + DC + 2)) begin
                n_err++;
                $display("FAIL press_level edge %0d: got %b, want %b", edge_idx, PRESSED,
                         (edge_idx >= e0 + DC + 2));
            end
        end
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL press_event: got none, want kind %0d at edge %0d",
                         ex.kind, ex.edge_no);
            end else begin
                ob = obs_q.pop_front();
                if (ob.kind !== ex.kind || ob.edge_no !== ex.edge_no) begin
                    n_err++;
                    $display("FAIL press_event: got kind %0d edge %0d, want kind %0d edge %0d",
                             ob.kind, ob.edge_no, ex.kind, ex.edge_no);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL press_extra: got %0d extra pulses (first kind %0d), want 0",
                     obs_q.size(), obs_q[0].kind);
        end
        obs_q.delete();
    endtask

    task automatic test_release_bounce();
        int e0;
        ev_t ex;
        ev_t ob;
        // Short release glitch while held: must be rejected.
        BUT = 1'b1;
        repeat (3) tick();
        BUT = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++;
            if (PRESSED !== 1'b1) begin
                n_err++;
                $display("FAIL glitch_level edge %0d: got %b, want 1", edge_idx, PRESSED);
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL glitch_pulses: got %0d pulses, want 0", obs_q.size());
        end
        obs_q.delete();
        // Genuine release.
        BUT = 1'b1;
        e0  = edge_idx + 1;
        exp_q.push_back('{EV_RELEASE, e0 + DC + 2});
        for (int i = 0; i < DC + 8; i++) begin
            tick();
            n_vec++;
            if (PRESSED !== (edge_idx < e0 + DC + 2)) begin
                n_err++;
                $display("FAIL release_level edge %0d: got %b, want %b", edge_idx, PRESSED,
                         (edge_idx < e0 + DC + 2));
            end
        end
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL release_event: got none, want kind %0d at edge %0d",
                         ex.kind, ex.edge_no);
            end else begin
                ob = obs_q.pop_front();
                if (ob.kind !== ex.kind || ob.edge_no !== ex.edge_no) begin
                    n_err++;
                    $display("FAIL release_event: got kind %0d edge %0d, want kind %0d edge %0d",
                             ob.kind, ob.edge_no, ex.kind, ex.edge_no);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL release_extra: got %0d extra pulses, want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_press_bounce();
        for (int i = 0; i < 20; i++) begin
            BUT = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            n_vec++;
            if (PRESSED !== 1'b0) begin
                n_err++;
                $display("FAIL bounce_level edge %0d: got %b, want 0", edge_idx, PRESSED);
            end
        end
        BUT = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++;
            if (PRESSED !== 1'b0) begin
                n_err++;
                $display("FAIL bounce_settle edge %0d: got %b, want 0", edge_idx, PRESSED);
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL bounce_pulses: got %0d pulses (first kind %0d), want 0",
                     obs_q.size(), obs_q[0].kind);
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid_press();
        int e0;
        ev_t ex;
        ev_t ob;
        BUT = 1'b0;
        e0  = edge_idx + 1;
        exp_q.push_back('{EV_PRESS, e0 + DC + 2});
        for (int i = 0; i < DC + 6; i++) tick();
        n_vec++;
        if (PRESSED !== 1'b1) begin
            n_err++;
            $display("FAIL midpress_level: got %b, want 1", PRESSED);
        end
        RST_N = 1'b0;
        #1;
        n_vec++;
        if ({PRESS, RELEASE, PRESSED, LONG} !== 4'b0000) begin
            n_err++;
            $display("FAIL midpress_reset: got %b, want 0000", {PRESS, RELEASE, PRESSED, LONG});
        end
        repeat (2) tick();
        RST_N = 1'b1;
        e0    = edge_idx + 1;
        exp_q.push_back('{EV_PRESS, e0 + DC + 2});
        for (int i = 0; i < DC + 8; i++) tick();
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL midpress_event: got none, want kind %0d at edge %0d",
                         ex.kind, ex.edge_no);
            end else begin
                ob = obs_q.pop_front();
                if (ob.kind !== ex.kind || ob.edge_no !== ex.edge_no) begin
                    n_err++;
                    $display("FAIL midpress_event: got kind %0d edge %0d, want kind %0d edge %0d",
                             ob.kind, ob.edge_no, ex.kind, ex.edge_no);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL midpress_extra: got %0d extra pulses (first kind %0d), want 0",
                     obs_q.size(), obs_q[0].kind);
        end
        n_vec++;
        if (PRESSED !== 1'b1) begin
            n_err++;
            $display("FAIL midpress_repress_level: got %b, want 1", PRESSED);
        end
        obs_q.delete();
    endtask

    initial begin
        RST_N = 1'b0;
        BUT   = 1'b1;
        test_reset();
        test_press_long();
        test_release_bounce();
        test_press_bounce();
        test_reset_mid_press();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
